// File: rtl/stream_video_frame_sanitizer.sv
// -----------------------------------------------------------------------------
// stream_video_frame_sanitizer
//
// Forces a 24-bit RGB AXI4-Stream video path into exact frame geometry before it
// reaches the convolution filter: IMG_HEIGHT lines of IMG_WIDTH pixels, tuser
// on pixel (0,0) and tlast on the last pixel of every line. Short lines and
// frames are padded with PAD_VALUE. Long lines are truncated. Data that
// arrives before a start of frame is discarded. Each anomaly sets a sticky
// flag in err_flags.
//
// Ports
//   clk, reset              clock; synchronous active-low reset
//   s_axis_video_*          input stream (tdata/tvalid/tready/tuser/tlast)
//   m_axis_video_*          output stream, driven from a single register slice
//   err_flags[3:0]          sticky: [0] short line, [1] long line,
//                           [2] early SOF, [3] discarded pre-SOF beat
//   err_clr                 synchronous clear of err_flags (wins over a set)
// -----------------------------------------------------------------------------
module stream_video_frame_sanitizer #(
  parameter int          IMG_WIDTH  = 64,
  parameter int          IMG_HEIGHT = 48,
  parameter logic [23:0] PAD_VALUE  = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tuser,
  input  logic        s_axis_video_tlast,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [3:0]  err_flags,
  input  logic        err_clr
);

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,       // waiting for a start-of-frame beat
    PASS,       // forwarding pixels of the current frame
    PAD_LINE,   // filling the rest of a short line
    PAD_FRAME,  // filling the rest of a frame cut short by an early SOF
    DROP        // discarding the tail of a long line
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] col_q, row_q;

  logic        slot_free;
  logic        at_end_col;
  logic        at_end_frame;
  logic        take_pixel;   // accept the input beat as the next pixel
  logic        load;         // load a beat into the output slot this cycle
  logic [23:0] load_data;
  logic [3:0]  err_set;

  assign slot_free    = !m_axis_video_tvalid || m_axis_video_tready;
  assign at_end_col   = (col_q == LAST_COL);
  assign at_end_frame = at_end_col && (row_q == LAST_ROW);

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d             = state_q;
    s_axis_video_tready = 1'b0;
    take_pixel          = 1'b0;
    load                = 1'b0;
    load_data           = PAD_VALUE;
    err_set             = 4'b0000;

    case (state_q)
      IDLE: begin
        s_axis_video_tready = slot_free;
        if (s_axis_video_tvalid && slot_free) begin
          if (s_axis_video_tuser) take_pixel = 1'b1;
          else                    err_set[3] = 1'b1;
        end
      end

      PASS: begin
        // A mid-frame SOF is held on the input; it is taken later from IDLE.
        s_axis_video_tready = slot_free && !(s_axis_video_tvalid && s_axis_video_tuser);
        if (s_axis_video_tvalid && s_axis_video_tuser) begin
          err_set[2] = 1'b1;
          state_d    = PAD_FRAME;
        end else begin
          take_pixel = s_axis_video_tvalid && slot_free;
        end
      end

      PAD_LINE: begin
        if (slot_free) begin
          load = 1'b1;
          if (at_end_col) state_d = at_end_frame ? IDLE : PASS;
        end
      end

      PAD_FRAME: begin
        if (slot_free) begin
          load = 1'b1;
          if (at_end_frame) state_d = IDLE;
        end
      end

      DROP: begin
        s_axis_video_tready = !(s_axis_video_tvalid && s_axis_video_tuser);
        if (s_axis_video_tvalid) begin
          if (s_axis_video_tuser) begin
            err_set[2] = 1'b1;
            state_d    = PAD_FRAME;
          end else if (s_axis_video_tlast) begin
            state_d = PASS;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared handling of an accepted pixel (SOF from IDLE or a PASS beat).
    // The output tlast always follows position, so a short line's final beat
    // goes out with tlast=0 and a long line is cut with tlast=1.
    if (take_pixel) begin
      load      = 1'b1;
      load_data = s_axis_video_tdata;
      if (s_axis_video_tlast && !at_end_col) begin
        err_set[0] = 1'b1;
        state_d    = PAD_LINE;
      end else if (!s_axis_video_tlast && at_end_col) begin
        err_set[1] = 1'b1;
        state_d    = at_end_frame ? IDLE : DROP;
      end else begin
        state_d    = at_end_frame ? IDLE : PASS;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is sampled on the clock edge (synchronous, active-low).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q             <= IDLE;
      col_q               <= '0;
      row_q               <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
      err_flags           <= '0;
    end else begin
      state_q <= state_d;

      // Payload only changes when the slot is free, so it stays stable
      // under backpressure.
      if (slot_free) begin
        m_axis_video_tvalid <= load;
        if (load) begin
          m_axis_video_tdata <= load_data;
          m_axis_video_tuser <= (row_q == '0) && (col_q == '0);
          m_axis_video_tlast <= at_end_col;
        end
      end

      if (load) begin
        if (at_end_col) begin
          col_q <= '0;
          row_q <= at_end_frame ? '0 : row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end

      if (err_clr) err_flags <= '0;
      else         err_flags <= err_flags | err_set;
    end
  end

endmodule

// File: tb/tb_stream_video_frame_sanitizer.sv
// -----------------------------------------------------------------------------
// tb_stream_video_frame_sanitizer
//
// Directed bench for stream_video_frame_sanitizer with a 4x2 frame. A negedge
// monitor records every transferred output beat, counts input stalls and
// checks that the output payload holds while stalled. The initial block
// drives the directed scenarios and compares the recorded beats against
// hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_stream_video_frame_sanitizer;

  localparam int          W   = 4;
  localparam int          H   = 2;
  localparam logic [23:0] PAD = 24'hC0FFEE;

  logic        clk;
  logic        reset;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tuser;
  logic        s_tlast;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic [3:0]  err_flags;
  logic        err_clr;

  stream_video_frame_sanitizer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .PAD_VALUE (PAD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .s_axis_video_tdata (s_tdata),
    .s_axis_video_tvalid(s_tvalid),
    .s_axis_video_tready(s_tready),
    .s_axis_video_tuser (s_tuser),
    .s_axis_video_tlast (s_tlast),
    .m_axis_video_tdata (m_tdata),
    .m_axis_video_tvalid(m_tvalid),
    .m_axis_video_tready(m_tready),
    .m_axis_video_tuser (m_tuser),
    .m_axis_video_tlast (m_tlast),
    .err_flags          (err_flags),
    .err_clr            (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int hold_checks = 0;

  logic [25:0] out_q[$];
  logic [25:0] exp_q[$];

  logic        tog_en = 1'b0;
  int          pat_i  = 0;
  logic [3:0]  tr_pat = 4'b1001;   // m_tready sequence 1,0,0,1

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] beat(input logic [23:0] d, input logic u, input logic l);
    return {u, l, d};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  logic        stall_prev = 1'b0;
  logic [25:0] prev_beat;
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        hold_checks++;
        check("hold_stable", {5'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, {6'd1, prev_beat});
      end
      stall_prev = m_tvalid && !m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready) out_q.push_back({m_tuser, m_tlast, m_tdata});
      if (s_tvalid && !s_tready) stalls++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_en) begin
      m_tready = tr_pat[pat_i % 4];
      pat_i++;
    end
  endtask

  task automatic send(input logic [23:0] d, input logic u, input logic l);
    logic acc;
    int   n;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = s_tready;
      tick();
      n++;
    end
    if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check(tag, {28'd0, err_flags}, 32'd0);
  endtask

  task automatic check_out(input string tag);
    logic [25:0] got;
    check({tag, "_count"}, out_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      got = (i < out_q.size()) ? out_q[i] : '1;
      check($sformatf("%s_beat%0d", tag, i), {6'd0, got}, {6'd0, exp_q[i]});
    end
  endtask

  task automatic start_scenario();
    out_q.delete();
    exp_q.delete();
    stalls = 0;
  endtask

  initial begin
    reset    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    err_clr  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata",  {8'd0, m_tdata},   32'd0);
    check("rst_tuser",  {31'd0, m_tuser},  32'd0);
    check("rst_tlast",  {31'd0, m_tlast},  32'd0);
    check("rst_err",    {28'd0, err_flags}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: well-formed frame, one-cycle latency on the first beat
    start_scenario();
    for (int i = 0; i < 8; i++) begin
      send(24'(32'h100000 + i), i == 0, (i % 4) == 3);
      if (i == 0) begin
        check("s1_lat_valid", {31'd0, m_tvalid}, 32'd1);
        check("s1_lat_data",  {8'd0, m_tdata},   32'h100000);
        check("s1_lat_user",  {31'd0, m_tuser},  32'd1);
      end
      exp_q.push_back(beat(24'(32'h100000 + i), i == 0, (i % 4) == 3));
    end
    idle(4);
    check_out("s1");
    check("s1_err", {28'd0, err_flags}, 32'd0);

    // 2: short line 0 (2 pixels), normal line 1
    start_scenario();
    send(24'hA0, 1'b1, 1'b0);
    send(24'hA1, 1'b0, 1'b1);
    send(24'hC0, 1'b0, 1'b0);
    send(24'hC1, 1'b0, 1'b0);
    send(24'hC2, 1'b0, 1'b0);
    send(24'hC3, 1'b0, 1'b1);
    idle(4);
    exp_q = '{beat(24'hA0, 1, 0), beat(24'hA1, 0, 0), beat(PAD, 0, 0), beat(PAD, 0, 1),
              beat(24'hC0, 0, 0), beat(24'hC1, 0, 0), beat(24'hC2, 0, 0), beat(24'hC3, 0, 1)};
    check_out("s2");
    check("s2_stalls", stalls, 32'd2);
    check("s2_err", {28'd0, err_flags}, 32'b0001);
    clear_err("s2_clr");

    // 2b: tuser and tlast on the same beat in IDLE
    start_scenario();
    send(24'hB0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(24'(32'hB8 + i), 1'b0, i == 3);
    idle(4);
    exp_q = '{beat(24'hB0, 1, 0), beat(PAD, 0, 0), beat(PAD, 0, 0), beat(PAD, 0, 1),
              beat(24'hB8, 0, 0), beat(24'hB9, 0, 0), beat(24'hBA, 0, 0), beat(24'hBB, 0, 1)};
    check_out("s2b");
    check("s2b_err", {28'd0, err_flags}, 32'b0001);
    clear_err("s2b_clr");

    // 3: long line 0 (6 pixels), normal line 1
    start_scenario();
    for (int i = 0; i < 6; i++) send(24'(32'hD0 + i), i == 0, i == 5);
    for (int i = 0; i < 4; i++) send(24'(32'hE0 + i), 1'b0, i == 3);
    idle(4);
    exp_q = '{beat(24'hD0, 1, 0), beat(24'hD1, 0, 0), beat(24'hD2, 0, 0), beat(24'hD3, 0, 1),
              beat(24'hE0, 0, 0), beat(24'hE1, 0, 0), beat(24'hE2, 0, 0), beat(24'hE3, 0, 1)};
    check_out("s3");
    check("s3_err", {28'd0, err_flags}, 32'b0010);
    clear_err("s3_clr");

    // 4: pre-SOF beats discarded; err_clr beats a same-cycle set
    start_scenario();
    err_clr = 1'b1;
    send(24'hF0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("s4_clr_priority", {28'd0, err_flags}, 32'd0);
    send(24'hF1, 1'b0, 1'b0);
    send(24'hF2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(24'(32'h200000 + i), i == 0, (i % 4) == 3);
      exp_q.push_back(beat(24'(32'h200000 + i), i == 0, (i % 4) == 3));
    end
    idle(4);
    check_out("s4");
    check("s4_err", {28'd0, err_flags}, 32'b1000);
    clear_err("s4_clr");

    // 5: early SOF arriving at row 1 col 2
    start_scenario();
    for (int i = 0; i < 6; i++) send(24'(32'h300000 + i), i == 0, i == 3);
    for (int i = 0; i < 8; i++) send(24'(32'h400000 + i), i == 0, (i % 4) == 3);
    idle(4);
    exp_q = '{beat(24'h300000, 1, 0), beat(24'h300001, 0, 0), beat(24'h300002, 0, 0),
              beat(24'h300003, 0, 1), beat(24'h300004, 0, 0), beat(24'h300005, 0, 0),
              beat(PAD, 0, 0), beat(PAD, 0, 1)};
    for (int i = 0; i < 8; i++) exp_q.push_back(beat(24'(32'h400000 + i), i == 0, (i % 4) == 3));
    check_out("s5");
    check("s5_err", {28'd0, err_flags}, 32'b0100);
    clear_err("s5_clr");

    // 6: output backpressure 1,0,0,1 then reset mid-frame
    start_scenario();
    hold_checks = 0;
    pat_i  = 0;
    tog_en = 1'b1;
    for (int i = 0; i < 5; i++) send(24'(32'h500000 + i), i == 0, (i % 4) == 3);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    tog_en   = 1'b0;
    m_tready = 1'b1;
    check("s6_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("s6_rst_tdata",  {8'd0, m_tdata},   32'd0);
    check("s6_rst_tuser",  {31'd0, m_tuser},  32'd0);
    check("s6_rst_tlast",  {31'd0, m_tlast},  32'd0);
    check("s6_hold_seen",  {31'd0, hold_checks > 0}, 32'd1);
    check("s6_some_out",   {31'd0, out_q.size() > 0}, 32'd1);
    foreach (out_q[i])
      check($sformatf("s6_pre_beat%0d", i), {6'd0, out_q[i]},
            {6'd0, beat(24'(32'h500000 + i), i == 0, (i % 4) == 3)});
    reset = 1'b1;
    tick();
    start_scenario();
    for (int i = 0; i < 8; i++) begin
      send(24'(32'h600000 + i), i == 0, (i % 4) == 3);
      exp_q.push_back(beat(24'(32'h600000 + i), i == 0, (i % 4) == 3));
    end
    idle(4);
    check_out("s6_post");
    check("s6_err", {28'd0, err_flags}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
